ap_vector_mem: RTL and testbench
================================

Name: ap_vector_mem

Overview:
- Parametrised vector memory. Each entry holds NO_OF_UNITS lanes of ELEMENT_WIDTH bits; it serves as the next-generation vector store for the datapath units.
- Adds the following over the previous generation:
  - per-lane write mask;
  - registered read port with a valid flag;
  - address range checking;
  - a hardware clear sweep FSM, so the controller can zero the store between iterations without issuing DEPTH writes.

Parameters:
ELEMENT_WIDTH, 64, bits per lane element
NO_OF_UNITS, 8, lanes per entry
DEPTH, 2001, number of entries
ADDR_WIDTH, 32, address port width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
clear_start  in  1  one-cycle request to start the clear sweep
busy  out  1  high while the clear sweep runs
clear_done  out  1  one-cycle pulse after the last entry is cleared
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_lane_mask  in  NO_OF_UNITS  bit i enables write of lane i
wr_data  in  ELEMENT_WIDTH*NO_OF_UNITS  write data; lane i = bits [i*EW +: EW]
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  ELEMENT_WIDTH*NO_OF_UNITS  registered read data
rd_valid  out  1  rd_data valid this cycle
addr_err  out  1  one-cycle pulse on any out-of-range access

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - rd_data=0, rd_valid=0, busy=0, clear_done=0, addr_err=0.
  - FSM goes to IDLE; clear counter = 0.
  - Memory contents are not reset.
- Write (IDLE, wr_en=1, wr_addr<DEPTH):
  - At the edge, lane i of mem[wr_addr] is updated iff wr_lane_mask[i]=1; other lanes are kept.
  - mask=0 is a legal no-op.
- Read (IDLE, rd_en=1):
  - Latency 1: rd_data and rd_valid=1 appear the cycle after rd_en.
  - rd_valid=0 and rd_data holds its last value when no read was issued.
- Out of range (addr >= DEPTH):
  - Write: dropped.
  - Read: rd_valid=1, rd_data=0.
  - addr_err pulses 1 the cycle after, for either port. Simultaneous read and write errors give a single pulse.
- Same-address read and write in one cycle: rd_data returns the pre-write (old) contents, unless WR_BYPASS_EN is defined.
- FSM states:
  - IDLE: normal access. clear_start=1 -> CLEAR; counter=0, busy=1 from the next cycle.
  - CLEAR:
    - Writes all-zero to mem[counter] each cycle, then increments counter.
    - At counter==DEPTH-1: zeroes the final entry, goes to DONE.
    - External wr_en/rd_en are ignored (no write, rd_valid=0, no addr_err).
    - clear_start is ignored.
    - Sweep occupies exactly DEPTH cycles.
  - DONE: one cycle. clear_done=1, busy=0, then -> IDLE. Accesses issued in DONE are ignored.
- clear_start is sampled only in IDLE. Simultaneous clear_start and wr_en/rd_en in IDLE: the access completes normally, and the sweep starts next cycle.
- Reset mid-sweep: returns to IDLE immediately. Entries already cleared stay zero; the rest keep old data. No clear_done.
- Address counter width: clog2(DEPTH); comparisons use the full ADDR_WIDTH input.

Optional Feature:
WR_BYPASS_EN
- Defined:
  - A read and a write to the same in-range address in the same cycle return forwarded data.
  - Per lane: wr_data lane if wr_lane_mask[i]=1, else the stored lane.
- Undefined: old data is returned, as stated in Behaviour. No extra logic.

Test Plan:
- Reset, then write 0x11..(lane i = i+1) to addr 5 with mask 0xFF; read addr 5 -> next cycle rd_valid=1, lane i = i+1.
- Write addr 5 with mask 0x0F, all lanes 0xAA; read addr 5 -> lanes 0-3 = 0xAA, lanes 4-7 unchanged.
- Read addr DEPTH (2001) -> rd_valid=1, rd_data=0, addr_err=1 for one cycle; a write to 2001 leaves addr 0 and 2000 unchanged.
- Fill addr 0, 1000, 2000 with nonzero data; pulse clear_start:
  - busy=1 for 2001 cycles, then clear_done=1 for one cycle;
  - reads of all three addresses return 0;
  - a wr_en issued mid-sweep has no effect.
- Start sweep, assert rst_n=0 at sweep cycle 10:
  - busy=0 next cycle, no clear_done;
  - addr 3 reads 0, addr 1000 reads its old value.
- Write and read addr 7 in the same cycle (mask 0xFF, data 0x55 per lane, old 0x00):
  - without WR_BYPASS_EN: rd_data=0;
  - with WR_BYPASS_EN: rd_data = 0x55 per lane.

Source files
------------

// File: rtl/ap_vector_mem.sv
// ap_vector_mem
//   Lane-masked vector store with a registered read port, address range
//   checking and a hardware clear sweep that zeroes every entry.
//
//   Ports:
//     clk, rst_n      : clock (rising edge), synchronous active-low reset
//     clear_start     : one-cycle request to start the clear sweep (IDLE only)
//     busy            : high while the clear sweep runs
//     clear_done      : one-cycle pulse after the last entry is cleared
//     wr_en, wr_addr  : write request / address
//     wr_lane_mask    : bit i enables the write of lane i
//     wr_data         : write data, lane i = bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH]
//     rd_en, rd_addr  : read request / address
//     rd_data         : registered read data (holds when no read is issued)
//     rd_valid        : rd_data carries the result of last cycle's read
//     addr_err        : one-cycle pulse after any out-of-range access
//
//   Handshake: no back-pressure. A request presented with wr_en/rd_en at a
//   rising edge while the FSM is IDLE is accepted at that edge; the read
//   result is presented with rd_valid=1 in the following cycle only.
//
//   Build option: define WR_BYPASS_EN to forward same-cycle write data to a
//   read of the same address (per lane, masked lanes only). Without it the
//   read returns the pre-write contents.
module ap_vector_mem #(
  parameter int ELEMENT_WIDTH = 64,
  parameter int NO_OF_UNITS   = 8,
  parameter int DEPTH         = 2001,
  parameter int ADDR_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_start,
  output logic                                 busy,
  output logic                                 clear_done,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [NO_OF_UNITS-1:0]               wr_lane_mask,
  input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
  output logic                                 rd_valid,
  output logic                                 addr_err
);

  localparam int EW = ELEMENT_WIDTH;
  localparam int DW = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [CW-1:0]         LAST    = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           addr_err_q, addr_err_d;

  logic [DW-1:0]  mem [DEPTH];

  logic                   mem_we;
  logic [CW-1:0]          mem_waddr;
  logic [DW-1:0]          mem_wdata;
  logic [NO_OF_UNITS-1:0] mem_wmask;

  logic           wr_in_range, rd_in_range;
  logic [CW-1:0]  wr_idx, rd_idx;
  logic [DW-1:0]  rd_word, rd_fwd;

  // Range checks use the full address; only in-range indices reach the array.
  assign wr_in_range = (wr_addr < DEPTH_A);
  assign rd_in_range = (rd_addr < DEPTH_A);
  assign wr_idx      = wr_addr[CW-1:0];
  assign rd_idx      = rd_addr[CW-1:0];
  assign rd_word     = mem[rd_idx];

`ifdef WR_BYPASS_EN
  always_comb begin
    rd_fwd = rd_word;
    if (wr_en && wr_in_range && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NO_OF_UNITS; i++) begin
        if (wr_lane_mask[i]) rd_fwd[i*EW +: EW] = wr_data[i*EW +: EW];
      end
    end
  end
`else
  assign rd_fwd = rd_word;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_idx;
    mem_wdata  = wr_data;
    mem_wmask  = wr_lane_mask;
    case (state_q)
      ST_IDLE: begin
        mem_we     = wr_en && wr_in_range;
        addr_err_d = (wr_en && !wr_in_range) || (rd_en && !rd_in_range);
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_in_range ? rd_fwd : '0;
        end
        // An access in the same cycle still completes; the sweep starts next.
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wmask = '1;
        if (cnt_q == LAST) state_d = ST_DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage is not reset; a reset edge only suppresses the pending write so
  // an interrupted sweep leaves untouched entries intact.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      for (int i = 0; i < NO_OF_UNITS; i++) begin
        if (mem_wmask[i]) mem[mem_waddr][i*EW +: EW] <= mem_wdata[i*EW +: EW];
      end
    end
  end

  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = (state_q == ST_DONE);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ap_vector_mem.sv
module tb_ap_vector_mem;
  localparam int EW    = 64;
  localparam int NU    = 8;
  localparam int DEPTH = 2001;
  localparam int AW    = 32;
  localparam int DW    = EW * NU;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clear_start = 1'b0;
  logic          busy, clear_done;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NU-1:0] wr_lane_mask = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, addr_err;

  ap_vector_mem #(
    .ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .DEPTH(DEPTH), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .busy(busy),
    .clear_done(clear_done), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_lane_mask(wr_lane_mask), .wr_data(wr_data), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .addr_err(addr_err)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [DW-1:0] seq_lanes();
    logic [DW-1:0] r;
    for (int i = 0; i < NU; i++) r[i*EW +: EW] = EW'(i + 1);
    return r;
  endfunction

  // What a read of ra returns, given the write presented in the same cycle.
  function automatic logic [DW-1:0] exp_read(input logic we, input logic [AW-1:0] wa,
                                             input logic [NU-1:0] m, input logic [DW-1:0] wd,
                                             input logic [AW-1:0] ra);
    logic [DW-1:0] r;
    if (ra >= DEPTH) return '0;
    r = model[int'(ra)];
`ifdef WR_BYPASS_EN
    if (we && wa == ra)
      for (int i = 0; i < NU; i++) if (m[i]) r[i*EW +: EW] = wd[i*EW +: EW];
`else
    if (we && wa == ra && m != 0) r = r;  // old contents are returned
`endif
    return r;
  endfunction

  task automatic model_write(input logic we, input logic [AW-1:0] wa,
                             input logic [NU-1:0] m, input logic [DW-1:0] wd);
    if (we && wa < DEPTH)
      for (int i = 0; i < NU; i++)
        if (m[i]) model[int'(wa)][i*EW +: EW] = wd[i*EW +: EW];
  endtask

  task automatic model_zero(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) model[a] = '0;
  endtask

  // ---------------- driver tasks ----------------
  // One IDLE-state cycle: present the request, take the edge, check results.
  task automatic access(input logic we, input logic [AW-1:0] wa, input logic [NU-1:0] m,
                        input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                        input logic cs, input string tag);
    logic exp_err;
    wr_en = we; wr_addr = wa; wr_lane_mask = m; wr_data = wd;
    rd_en = re; rd_addr = ra; clear_start = cs;
    if (re) exp_q.push_back(exp_read(we, wa, m, wd, ra));
    exp_err = (we && wa >= DEPTH) || (re && ra >= DEPTH);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
    model_write(we, wa, m, wd);
    if (re) begin
      last_rd = exp_q.pop_front();
      check({tag, "_rdv"}, DW'(rd_valid), DW'(1));
    end else begin
      check({tag, "_rdv"}, DW'(rd_valid), DW'(0));
    end
    check({tag, "_rdata"}, rd_data, last_rd);
    check({tag, "_err"}, DW'(addr_err), DW'(exp_err));
    check({tag, "_busy"}, DW'(busy), DW'(cs));
    check({tag, "_done"}, DW'(clear_done), DW'(0));
  endtask

  task automatic rd(input logic [AW-1:0] ra, input string tag);
    access(1'b0, '0, '0, '0, 1'b1, ra, 1'b0, tag);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [NU-1:0] m,
                    input logic [DW-1:0] wd, input string tag);
    access(1'b1, wa, m, wd, 1'b0, '0, 1'b0, tag);
  endtask

  // Follows a sweep already requested; pokes ignored accesses mid-sweep and
  // in the DONE cycle.
  task automatic run_sweep(input string tag);
    int busy_cnt = 0;
    bit done = 1'b0;
    for (int c = 0; c < DEPTH + 50 && !done; c++) begin
      if (busy) busy_cnt++;
      if (clear_done) begin
        done = 1'b1;
        check({tag, "_done_busy"}, DW'(busy), DW'(0));
      end else if (c > 0) begin
        check({tag, "_sweep_rdv"}, DW'(rd_valid), DW'(0));
        check({tag, "_sweep_err"}, DW'(addr_err), DW'(0));
        check({tag, "_sweep_hold"}, rd_data, last_rd);
      end
      wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
      if (c == 500 || done) begin
        // Entry 100 (or 0) is already cleared, so any leaked write would show.
        wr_en = 1'b1; wr_addr = done ? 0 : 100; wr_lane_mask = '1; wr_data = '1;
        rd_en = 1'b1; rd_addr = done ? 0 : DEPTH;
        clear_start = 1'b1;
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
    check({tag, "_done_seen"}, DW'(done), DW'(1));
    check({tag, "_busy_cycles"}, DW'(busy_cnt), DW'(DEPTH));
    check({tag, "_after_rdv"}, DW'(rd_valid), DW'(0));
    check({tag, "_after_busy"}, DW'(busy), DW'(0));
    model_zero(0, DEPTH - 1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k < 6)  return AW'($urandom_range(0, 15));
    if (k == 6) return AW'(DEPTH - 1);
    if (k == 7) return AW'(DEPTH);
    if (k == 8) return AW'($urandom_range(DEPTH + 1, 5000));
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d0, d1, d2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", rd_data, '0);
    check("rst_rdv", DW'(rd_valid), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(clear_done), DW'(0));
    check("rst_err", DW'(addr_err), DW'(0));
    rst_n = 1'b1;
    last_rd = '0;

    // Bring the whole store to a known state.
    access(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, "init_cs");
    run_sweep("init");

    // Full and partial lane writes.
    wr(5, 8'hFF, seq_lanes(), "w5_full");
    rd(5, "r5_full");
    check("r5_full_const", rd_data, seq_lanes());
    wr(5, 8'h0F, {NU{64'hAA}}, "w5_part");
    rd(5, "r5_part");
    d0 = seq_lanes();
    for (int i = 0; i < 4; i++) d0[i*EW +: EW] = 64'hAA;
    check("r5_part_const", rd_data, d0);
    wr(5, 8'h00, rand_data(), "w5_nomask");
    rd(5, "r5_nomask");

    // Out-of-range accesses and the top in-range entry.
    rd(DEPTH, "r_oor");
    check("r_oor_const", rd_data, '0);
    wr(DEPTH, 8'hFF, '1, "w_oor");
    rd(0, "r0_after_oor");
    rd(DEPTH - 1, "rtop_after_oor");
    access(1'b1, 32'hFFFF_FFFF, 8'hFF, '1, 1'b1, 32'hFFFF_FFFF, 1'b0, "both_oor");
    wr(DEPTH - 1, 8'hFF, rand_data(), "w_top");
    rd(DEPTH - 1, "r_top");

    // Same-address read and write.
    access(1'b1, 7, 8'hFF, {NU{64'h55}}, 1'b1, 7, 1'b0, "rw7");
`ifdef WR_BYPASS_EN
    check("rw7_const", rd_data, {NU{64'h55}});
`else
    check("rw7_const", rd_data, '0);
`endif
    rd(7, "r7_after");

    // Fill, then sweep with a read issued alongside the start request.
    d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
    wr(0, 8'hFF, d0, "fill0");
    wr(1000, 8'hFF, d1, "fill1000");
    wr(DEPTH - 1, 8'hFF, d2, "fill2000");
    access(1'b0, '0, '0, '0, 1'b1, 1000, 1'b1, "sweep_cs");
    check("sweep_cs_old", rd_data, d1);
    run_sweep("sweep");
    rd(0, "clr0");
    rd(1000, "clr1000");
    rd(DEPTH - 1, "clr2000");
    rd(100, "clr100");

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa, ra;
      logic we, re;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = rand_addr();
      ra = ($urandom_range(0, 3) == 0) ? wa : rand_addr();
      access(we, wa, NU'($urandom), rand_data(), re, ra, 1'b0, "rnd");
    end

    // Reset in the middle of a sweep.
    d1 = rand_data();
    wr(3, 8'hFF, rand_data(), "pre3");
    wr(1000, 8'hFF, d1, "pre1000");
    access(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, "mid_cs");
    for (int k = 1; k < 10; k++) begin
      @(posedge clk); #1;
      check("mid_busy", DW'(busy), DW'(1));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rd = '0;
    model_zero(0, 9);
    check("mid_rst_busy", DW'(busy), DW'(0));
    check("mid_rst_done", DW'(clear_done), DW'(0));
    check("mid_rst_rdv", DW'(rd_valid), DW'(0));
    check("mid_rst_rdata", rd_data, '0);
    rd(3, "mid_r3");
    rd(1000, "mid_r1000");
    check("mid_r1000_const", rd_data, d1);
    rd(20, "mid_r20");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
